// File: rtl/reduce_pkg.sv
// Shared types for the reduction engine: operating modes and FSM states.
package reduce_pkg;

    typedef enum logic [1:0] {
        RED_SUM = 2'd0,
        RED_MAX = 2'd1,
        RED_MIN = 2'd2,
        RED_XOR = 2'd3
    } red_mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } red_state_t;

endpackage

// File: rtl/reduce_engine_if.sv
// Request/result bus of the reduction engine plus its memory read port.
//
// Handshake: the requester raises start with mode/base_addr/count; the engine
// accepts it only while idle (busy=0) and latches the parameters on that edge.
// busy stays high until the request completes; done pulses for exactly one
// cycle with result/overflow valid, and result/overflow then hold until the
// next done. start seen while busy is dropped, never queued. The read port is
// asynchronous: rd_data must reflect rd_addr within the same cycle.
interface reduce_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 12
);
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              overflow;

    // Requester side (also supplies memory read data).
    modport master (
        output start, mode, base_addr, count, rd_data,
        input  rd_addr, busy, done, result, overflow
    );

    // Engine side.
    modport slave (
        input  start, mode, base_addr, count, rd_data,
        output rd_addr, busy, done, result, overflow
    );
endinterface

// File: rtl/reduce_alu.sv
// One fold step of the reduction: combines the running accumulator with a
// zero-extended memory word according to the selected mode.
module reduce_alu
    import reduce_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
) (
    input  red_mode_t         mode_i,
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ACC_W-1:0]  next_acc_o,
    output logic              sat_o
);
    logic [ACC_W-1:0] data_ext;
    logic [ACC_W:0]   sum;

    assign data_ext = ACC_W'(data_i);
    // Extra carry bit tells whether the sum left the accumulator range.
    assign sum      = {1'b0, acc_i} + {1'b0, data_ext};

    // Select the folded value; SUM clamps to all-ones on carry-out.
    always_comb begin
        next_acc_o = acc_i;
        sat_o      = 1'b0;
        unique case (mode_i)
            RED_SUM: begin
                if (sum[ACC_W]) begin
                    next_acc_o = '1;
                    sat_o      = 1'b1;
                end else begin
                    next_acc_o = sum[ACC_W-1:0];
                end
            end
            RED_MAX: next_acc_o = (data_ext > acc_i) ? data_ext : acc_i;
            RED_MIN: next_acc_o = (data_ext < acc_i) ? data_ext : acc_i;
            RED_XOR: next_acc_o = acc_i ^ data_ext;
            default: next_acc_o = acc_i;
        endcase
    end
endmodule

// File: rtl/reduce_engine.sv
// Reduction engine: walks a window of a register-file memory, one word per
// cycle, through its asynchronous read port and folds the words into a
// single result (SUM with saturation, MAX, MIN or XOR).
module reduce_engine
    import reduce_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    reduce_engine_if.slave   bus,
    output red_state_t       state_o
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    // MIN starts from the largest possible word so the first word always wins.
    localparam logic [ACC_W-1:0] MIN_ID = ACC_W'({DATA_W{1'b1}});

    if (ACC_W < DATA_W) begin : g_bad_acc_w
        $error("reduce_engine: ACC_W must be >= DATA_W");
    end

    red_state_t        state_q;
    red_mode_t         mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   idx_q;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;
    logic [ACC_W-1:0]  result_q;
    logic              overflow_q;

    logic [ADDR_W:0]   cnt_d;
    logic [ACC_W-1:0]  acc_d;
    logic              sat;
    logic              last_word;

    assign cnt_d     = (bus.count > DEPTH_V) ? DEPTH_V : bus.count;
    assign last_word = (idx_q == cnt_q - 1'b1);

    reduce_alu #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_alu (
        .mode_i     (mode_q),
        .acc_i      (acc_q),
        .data_i     (bus.rd_data),
        .next_acc_o (acc_d),
        .sat_o      (sat)
    );

    // Control FSM with index counter and result registers. The result is
    // written on the edge that enters DONE so it is valid alongside done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= RED_SUM;
            base_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q <= red_mode_t'(bus.mode);
                        base_q <= bus.base_addr;
                        cnt_q  <= cnt_d;
                        idx_q  <= '0;
                        ovf_q  <= 1'b0;
                        acc_q  <= (red_mode_t'(bus.mode) == RED_MIN) ? MIN_ID : '0;
                        if (cnt_d == '0) begin
                            result_q   <= '0;
                            overflow_q <= 1'b0;
                            state_q    <= S_DONE;
                        end else begin
                            state_q    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_q | sat;
                    if (last_word) begin
                        result_q   <= acc_d;
                        overflow_q <= ovf_q | sat;
                        idx_q      <= '0;
                        state_q    <= S_DONE;
                    end else begin
                        idx_q      <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // idx is zero outside RUN, so the read address rests on the latched base.
    assign bus.rd_addr  = base_q + idx_q[ADDR_W-1:0];
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_reduce_engine.sv
// Self-checking bench for reduce_engine: directed cases, reset/overlap cases
// and randomized windows compared against a plain arithmetic reference.
module tb_reduce_engine;
    import reduce_pkg::*;

    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reduce_engine_if #(.DATA_W(8), .ADDR_W(4), .ACC_W(12)) bus ();
    reduce_engine_if #(.DATA_W(8), .ADDR_W(4), .ACC_W(8))  bus8 ();

    logic [7:0] mem  [DEPTH];
    logic [7:0] mem8 [DEPTH];
    red_state_t st, st8;

    assign bus.rd_data  = mem[bus.rd_addr];
    assign bus8.rd_data = mem8[bus8.rd_addr];

    reduce_engine #(.DATA_W(8), .ADDR_W(4), .ACC_W(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (st)
    );

    reduce_engine #(.DATA_W(8), .ADDR_W(4), .ACC_W(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus8),
        .state_o (st8)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: fold the window with plain integer arithmetic.
    function automatic void ref_reduce(input bit use8, input int m, input int base,
                                       input int cnt_in, output int res, output int ovf);
        int     n, w, mx, mn, x, maxv;
        longint sum;
        n    = (cnt_in > DEPTH) ? DEPTH : cnt_in;
        maxv = use8 ? 255 : 4095;
        sum  = 0; mx = 0; mn = 255; x = 0;
        for (int k = 0; k < n; k++) begin
            w = use8 ? int'(mem8[(base + k) % DEPTH]) : int'(mem[(base + k) % DEPTH]);
            sum += w;
            if (w > mx) mx = w;
            if (w < mn) mn = w;
            x = x ^ w;
        end
        ovf = 0;
        case (m)
            0: begin
                res = (sum > maxv) ? maxv : int'(sum);
                ovf = (sum > maxv) ? 1 : 0;
            end
            1: res = mx;
            2: res = (n == 0) ? 0 : mn;
            default: res = x;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Issue one request on the 12-bit engine and follow it to done.
    // With scramble set, request inputs are disturbed while the engine is busy.
    task automatic run_op(input int m, input int base, input int cnt_in, input bit scramble);
        int res, ovf, n, cyc;
        bit seen;
        ref_reduce(1'b0, m, base, cnt_in, res, ovf);
        exp_q.push_back(12'(res));
        n = (cnt_in > DEPTH) ? DEPTH : cnt_in;
        bus.start     = 1'b1;
        bus.mode      = 2'(m);
        bus.base_addr = 4'(base);
        bus.count     = 5'(cnt_in);
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                check_eq("busy_run", 32'(bus.busy), 32'd1);
                if (cyc <= n)
                    check_eq("rd_addr", 32'(bus.rd_addr), 32'((base + cyc - 1) % DEPTH));
                if (scramble) begin
                    bus.mode      = 2'($urandom_range(0, 3));
                    bus.base_addr = 4'($urandom_range(0, 15));
                    bus.count     = 5'($urandom_range(0, 31));
                    bus.start     = (cyc < n) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(cyc), 32'(n + 1));
        check_eq("busy_done", 32'(bus.busy), 32'd1);
        check_eq("result", 32'(bus.result), 32'(exp_q.pop_front()));
        check_eq("overflow", 32'(bus.overflow), 32'(ovf));
        @(posedge clk); #1;
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_done", 32'(bus.done), 32'd0);
        check_eq("hold_result", 32'(bus.result), 32'(res));
        check_eq("rd_addr_idle", 32'(bus.rd_addr), 32'(base % DEPTH));
    endtask

    // Same flow on the 8-bit-accumulator engine, without disturbance.
    task automatic run8(input int m, input int base, input int cnt_in);
        int res, ovf, n, cyc;
        bit seen;
        ref_reduce(1'b1, m, base, cnt_in, res, ovf);
        n = (cnt_in > DEPTH) ? DEPTH : cnt_in;
        bus8.start     = 1'b1;
        bus8.mode      = 2'(m);
        bus8.base_addr = 4'(base);
        bus8.count     = 5'(cnt_in);
        @(posedge clk); #1;
        bus8.start = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus8.done) seen = 1'b1;
        end
        check_eq("acc8_done_seen", 32'(seen), 32'd1);
        check_eq("acc8_latency", 32'(cyc), 32'(n + 1));
        check_eq("acc8_result", 32'(bus8.result), 32'(res));
        check_eq("acc8_overflow", 32'(bus8.overflow), 32'(ovf));
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dones;
        bus.start  = 1'b0; bus.mode  = '0; bus.base_addr  = '0; bus.count  = '0;
        bus8.start = 1'b0; bus8.mode = '0; bus8.base_addr = '0; bus8.count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = 8'(i + 1);
            mem8[i] = 8'hFF;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_result", 32'(bus.result), 32'd0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
        check_eq("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check_eq("rst_state", 32'(st), 32'(S_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed windows over mem[i] = i+1
        run_op(0, 0, 16, 1'b0);   // SUM full memory
        run_op(1, 3, 5, 1'b0);    // MAX
        run_op(2, 14, 4, 1'b0);   // MIN across the wrap
        run_op(0, 14, 4, 1'b0);   // SUM across the wrap
        run_op(1, 5, 0, 1'b0);    // empty window
        run_op(0, 0, 31, 1'b0);   // count clamped to the depth

        // start held high: one done per accepted request (5-cycle period for 3 words)
        bus.mode = 2'd0; bus.base_addr = 4'd0; bus.count = 5'd3; bus.start = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check_eq("hold_start_dones", 32'(dones), 32'd4);
        check_eq("hold_start_result", 32'(bus.result), 32'd6);

        // Reset on the third RUN cycle abandons the run
        bus.mode = 2'd0; bus.base_addr = 4'd0; bus.count = 5'd16; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_done", 32'(bus.done), 32'd0);
        check_eq("midrst_result", 32'(bus.result), 32'd0);
        check_eq("midrst_rd_addr", 32'(bus.rd_addr), 32'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check_eq("midrst_no_done", 32'(dones), 32'd0);

        // Narrow accumulator: saturation, then XOR clears the flag
        run8(0, 0, 2);
        run8(3, 0, 2);

        // Randomized windows, with inputs disturbed while busy
        repeat (30) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 31)), 1'b1);
        end
        repeat (15) begin
            for (int i = 0; i < DEPTH; i++) mem8[i] = 8'($urandom_range(0, 255));
            run8(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
